// File: rtl/lc3_alu_pkg.sv
// lc3_alu_pkg: opcode constants, sequencer state encoding and nzp reset value
package lc3_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_DIV = 4'h7;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_LD  = 4'hB;
  localparam logic [3:0] OP_ILL = 4'hC;
  localparam logic [2:0] NZP_RST = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/lc3_nzp_gen.sv
// lc3_nzp_gen: 16-bit value (val_i) -> {n,z,p} condition flags (nzp_o)
module lc3_nzp_gen (
  input  logic [15:0] val_i,
  output logic [2:0]  nzp_o
);
  assign nzp_o = val_i[15] ? 3'b100 : (val_i == 16'h0000 ? 3'b010 : 3'b001);
endmodule

// File: rtl/lc3_alu_seq_ctrl.sv
// lc3_alu_seq_ctrl: IDLE/DECODE/EXEC/WB sequencer; instr handshake in, rf read ports, alu drive, wb strobe, nzp/done/illegal out
module lc3_alu_seq_ctrl
  import lc3_alu_pkg::*;
#(
  parameter int MULDIV_LAT = 2,
  parameter int RF_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [RF_AW-1:0] rf_addr_a,
  output logic [RF_AW-1:0] rf_addr_b,
  input  logic [15:0]      rf_data_a,
  input  logic [15:0]      rf_data_b,
  output logic [15:0]      alu_opcode,
  output logic [15:0]      alu_rega,
  output logic [15:0]      alu_regb,
  input  logic [15:0]      alu_res,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_addr,
  output logic [15:0]      wb_data,
  output logic [2:0]       nzp,
  output logic             done,
  output logic             illegal
);
  localparam int CW = MULDIV_LAT > 1 ? $clog2(MULDIV_LAT) : 1;
  state_t state_q, state_d;
  logic [15:0] ir_q, alu_opcode_q, alu_rega_q, alu_regb_q, wb_data_q;
  logic [RF_AW-1:0] wb_addr_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] nzp_q, res_nzp;
  logic wb_en_q, done_q, illegal_q;
  logic [3:0] op;
  logic accept, bad_in, exec_last;
  assign op = ir_q[15:12];
  assign instr_ready = state_q == S_IDLE;
  assign accept = instr_valid & instr_ready;
  assign bad_in = instr[15:12] >= OP_ILL;
  assign exec_last = state_q == S_EXEC && cnt_q == '0;
  assign rf_addr_a = RF_AW'(ir_q[11:9]);
  assign rf_addr_b = RF_AW'(ir_q[2:0]);
  assign alu_opcode = alu_opcode_q;
  assign alu_rega = alu_rega_q;
  assign alu_regb = alu_regb_q;
  assign wb_en = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign nzp = nzp_q;
  assign done = done_q;
  assign illegal = illegal_q;
  lc3_nzp_gen u_nzp (.val_i(alu_res), .nzp_o(res_nzp));
  always_comb
    state_d = state_q == S_IDLE   ? (accept ? S_DECODE : S_IDLE) :
              state_q == S_DECODE ? (op >= OP_ILL ? S_IDLE : S_EXEC) :
              state_q == S_EXEC   ? (cnt_q == '0 ? S_WB : S_EXEC) : S_IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      cnt_q <= '0;
      alu_opcode_q <= '0;
      alu_rega_q <= '0;
      alu_regb_q <= '0;
      wb_en_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      nzp_q <= NZP_RST;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= accept && bad_in;
      done_q <= (accept && bad_in) || exec_last;
      wb_en_q <= exec_last && op != OP_CMP;
      if (accept) ir_q <= instr;
      if (state_q == S_DECODE && op < OP_ILL) begin
        alu_opcode_q <= op == OP_CMP ? {OP_SUB, ir_q[11:0]} : ir_q;
        alu_rega_q <= rf_data_a;
        alu_regb_q <= rf_data_b;
        cnt_q <= (op == OP_MUL || op == OP_DIV) ? CW'(MULDIV_LAT - 1) : '0;
      end
      if (state_q == S_EXEC && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (exec_last && op != OP_CMP) begin
        wb_addr_q <= RF_AW'(ir_q[11:9]);
        wb_data_q <= op == OP_LD ? (ir_q[8] ? alu_regb_q : {8'h00, ir_q[7:0]}) : alu_res;
      end
      if (exec_last && op != OP_LD) nzp_q <= res_nzp;
    end
  end
endmodule

// File: tb/tb_lc3_alu_seq_ctrl.sv
// tb_lc3_alu_seq_ctrl: table-driven check of the LC3 ALU sequencer with register-file and ALU models
module tb_lc3_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] instr = '0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [2:0] rf_addr_a, rf_addr_b, wb_addr, nzp;
  logic [15:0] rf_data_a, rf_data_b, alu_opcode, alu_rega, alu_regb, alu_res, wb_data;
  logic wb_en, done, illegal;
  logic [15:0] regs [8];
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [15:0] ins, ra, rb, aop, data;
    int cyc;
    logic wen;
    logic [2:0] addr, nzp;
  } vec_t;
  vec_t vecs [10];
  always #5 clk = ~clk;
  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];
  always_comb begin
    alu_res = alu_rega + alu_regb;
    case (alu_opcode[15:12])
      4'h2: alu_res = alu_rega - alu_regb;
      4'h6: alu_res = 16'(alu_rega * alu_regb);
      4'h7: alu_res = alu_regb != 0 ? alu_rega / alu_regb : 16'hFFFF;
      default: ;
    endcase
  end
  lc3_alu_seq_ctrl #(.MULDIV_LAT(2), .RF_AW(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .alu_opcode(alu_opcode), .alu_rega(alu_rega), .alu_regb(alu_regb), .alu_res(alu_res),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .nzp(nzp), .done(done), .illegal(illegal)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int dc;
    logic seen;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    vecs[0] = '{16'h0202, 16'h0005, 16'h0003, 16'h0202, 16'h0008, 3, 1'b1, 3'd1, 3'b001};
    vecs[1] = '{16'h2202, 16'h0003, 16'h0005, 16'h2202, 16'hFFFE, 3, 1'b1, 3'd1, 3'b100};
    vecs[2] = '{16'hB2A5, 16'h0000, 16'h0000, 16'hB2A5, 16'h00A5, 3, 1'b1, 3'd1, 3'b100};
    vecs[3] = '{16'hB302, 16'h0000, 16'h1234, 16'hB302, 16'h1234, 3, 1'b1, 3'd1, 3'b100};
    vecs[4] = '{16'hA202, 16'h0007, 16'h0007, 16'h2202, 16'h0000, 3, 1'b0, 3'd0, 3'b010};
    vecs[5] = '{16'h6202, 16'h0003, 16'h0004, 16'h6202, 16'h000C, 4, 1'b1, 3'd1, 3'b001};
    vecs[6] = '{16'h7202, 16'h0010, 16'h0004, 16'h7202, 16'h0004, 4, 1'b1, 3'd1, 3'b001};
    vecs[7] = '{16'h0202, 16'h7FFF, 16'h0001, 16'h0202, 16'h8000, 3, 1'b1, 3'd1, 3'b100};
    vecs[8] = '{16'h0202, 16'hFFFF, 16'h0001, 16'h0202, 16'h0000, 3, 1'b1, 3'd1, 3'b010};
    vecs[9] = '{16'h0A05, 16'h0006, 16'h0006, 16'h0A05, 16'h000C, 3, 1'b1, 3'd5, 3'b001};
    repeat (2) @(negedge clk);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_nzp", 16'(nzp), 16'h2);
    chk("rst_pulses", {13'h0, wb_en, done, illegal}, 16'h0);
    chk("rst_alu_op", alu_opcode, 16'h0);
    chk("rst_wb_data", wb_data, 16'h0);
    rst = 1'b0;
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      regs[vecs[v].ins[11:9]] = vecs[v].ra;
      regs[vecs[v].ins[2:0]] = vecs[v].rb;
      instr = vecs[v].ins;
      instr_valid = 1'b1;
      chk($sformatf("v%0d_ready_idle", v), 16'(instr_ready), 16'h1);
      @(posedge clk);
      dc = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        instr_valid = 1'b0;
        if (c == 2) chk($sformatf("v%0d_alu_opcode", v), alu_opcode, vecs[v].aop);
        if (done) begin
          dc = c;
          break;
        end
      end
      chk($sformatf("v%0d_done_cycle", v), 16'(dc), 16'(vecs[v].cyc));
      chk($sformatf("v%0d_wb_en", v), 16'(wb_en), 16'(vecs[v].wen));
      if (vecs[v].wen) begin
        chk($sformatf("v%0d_wb_addr", v), 16'(wb_addr), 16'(vecs[v].addr));
        chk($sformatf("v%0d_wb_data", v), wb_data, vecs[v].data);
      end
      chk($sformatf("v%0d_nzp", v), 16'(nzp), 16'(vecs[v].nzp));
      chk($sformatf("v%0d_wb_ready", v), {14'h0, instr_ready, illegal}, 16'h0);
      @(negedge clk);
      chk($sformatf("v%0d_after", v), {13'h0, instr_ready, wb_en, done}, 16'h4);
    end
    instr = 16'hC000;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_pulse", {13'h0, illegal, done, wb_en}, 16'h6);
    @(negedge clk);
    chk("ill_after", {13'h0, instr_ready, illegal, done}, 16'h4);
    chk("ill_nzp", 16'(nzp), 16'h1);
    regs[1] = 16'h0001;
    regs[2] = 16'h0001;
    instr = 16'h0202;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(instr_ready), 16'h1);
    chk("mid_rst_nzp", 16'(nzp), 16'h2);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | wb_en | done;
    end
    chk("mid_rst_no_wb", 16'(seen), 16'h0);
    chk("mid_rst_idle", {14'h0, instr_ready, nzp == 3'b010}, 16'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
